com_bus_arbiter: RTL and testbench

Arbiter for the shared common bus of the 4-core MESI cache system. It takes bus requests from the 8 processor-side cache controllers (DL cores 0-3 on indices 0-3, IL cores 0-3 on indices 4-7), the 4 snoop-side controllers and lower-level memory. It drives the `Com_Bus_Gnt_*` and `Mem_snoop_gnt` signals that the cache blocks and memory model consume. Processor transactions own the bus; snoop flushes and memory snoop service are nested inside the current processor ownership.

---
 rtl/arb_pkg.sv | 16 +
 rtl/rr_picker.sv | 31 +++
 rtl/com_bus_arbiter.sv | 114 +++++++++++
 tb/tb_com_bus_arbiter.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared types and sizing for the common-bus arbiter.
package arb_pkg;

  localparam int unsigned N_PROC_DEF  = 8;
  localparam int unsigned N_SNOOP_DEF = 4;
  localparam int unsigned OWNER_W     = $clog2(N_PROC_DEF);
  localparam int unsigned SNOOP_W     = $clog2(N_SNOOP_DEF);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PROC  = 2'd1,
    ST_SNOOP = 2'd2,
    ST_MEM   = 2'd3
  } arb_state_e;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first requester strictly after i_last, wrapping.
module rr_picker #(
  parameter int unsigned W  = 8,
  parameter int unsigned IW = (W > 1) ? $clog2(W) : 1
) (
  input  logic [W-1:0]  i_req,
  input  logic [IW-1:0] i_last,
  output logic [W-1:0]  o_onehot_c,
  output logic [IW-1:0] o_index_c,
  output logic          o_any_c
);

  logic [IW-1:0] w_cand;

  always_comb begin
    o_onehot_c = '0;
    o_index_c  = '0;
    o_any_c    = 1'b0;
    w_cand     = '0;
    // The last winner itself is visited last (i == W), so it only wins when alone.
    for (int unsigned i = 1; i <= W; i++) begin
      w_cand = IW'((32'(i_last) + i) % W);
      if (!o_any_c && i_req[w_cand]) begin
        o_any_c            = 1'b1;
        o_index_c          = w_cand;
        o_onehot_c[w_cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/com_bus_arbiter.sv
// Common-bus arbiter: processor ownership with nested snoop-flush / memory-snoop grants.
module com_bus_arbiter
  import arb_pkg::*;
#(
  parameter int unsigned N_PROC  = N_PROC_DEF,
  parameter int unsigned N_SNOOP = N_SNOOP_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_PROC-1:0]   Com_Bus_Req_proc,
  input  logic [N_SNOOP-1:0]  Com_Bus_Req_snoop,
  input  logic                Mem_snoop_req,
  output logic [N_PROC-1:0]   Com_Bus_Gnt_proc,
  output logic [N_SNOOP-1:0]  Com_Bus_Gnt_snoop_vec,
  output logic                Com_Bus_Gnt_snoop,
  output logic                Mem_snoop_gnt,
  output logic [OWNER_W-1:0]  Bus_owner
);

  arb_state_e           r_state;
  logic [OWNER_W-1:0]   r_proc_last;
  logic [SNOOP_W-1:0]   r_snoop_last;
  logic [OWNER_W-1:0]   r_owner;
  logic [SNOOP_W-1:0]   r_snoop_idx;
  logic [N_PROC-1:0]    r_gnt_proc;
  logic [N_SNOOP-1:0]   r_gnt_snoop;
  logic                 r_gnt_snoop_any;
  logic                 r_mem_gnt;

  logic [N_PROC-1:0]    w_proc_onehot;
  logic [OWNER_W-1:0]   w_proc_idx;
  logic                 w_proc_any;
  logic [N_SNOOP-1:0]   w_snoop_onehot;
  logic [SNOOP_W-1:0]   w_snoop_idx;
  logic                 w_snoop_any;

  rr_picker #(.W(N_PROC), .IW(OWNER_W)) u_proc_pick (
    .i_req      (Com_Bus_Req_proc),
    .i_last     (r_proc_last),
    .o_onehot_c (w_proc_onehot),
    .o_index_c  (w_proc_idx),
    .o_any_c    (w_proc_any)
  );

  rr_picker #(.W(N_SNOOP), .IW(SNOOP_W)) u_snoop_pick (
    .i_req      (Com_Bus_Req_snoop),
    .i_last     (r_snoop_last),
    .o_onehot_c (w_snoop_onehot),
    .o_index_c  (w_snoop_idx),
    .o_any_c    (w_snoop_any)
  );

  // Owner release is only honoured in PROC, so nested grants always finish first.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state         <= ST_IDLE;
      r_proc_last     <= OWNER_W'(N_PROC - 1);
      r_snoop_last    <= SNOOP_W'(N_SNOOP - 1);
      r_owner         <= '0;
      r_snoop_idx     <= '0;
      r_gnt_proc      <= '0;
      r_gnt_snoop     <= '0;
      r_gnt_snoop_any <= 1'b0;
      r_mem_gnt       <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_proc_any) begin
            r_gnt_proc  <= w_proc_onehot;
            r_owner     <= w_proc_idx;
            r_proc_last <= w_proc_idx;
            r_state     <= ST_PROC;
          end
        end
        ST_PROC: begin
          if (!Com_Bus_Req_proc[r_owner]) begin
            r_gnt_proc <= '0;
            r_state    <= ST_IDLE;
          end else if (w_snoop_any) begin
            r_gnt_snoop     <= w_snoop_onehot;
            r_gnt_snoop_any <= 1'b1;
            r_snoop_idx     <= w_snoop_idx;
            r_snoop_last    <= w_snoop_idx;
            r_state         <= ST_SNOOP;
          end else if (Mem_snoop_req) begin
            r_mem_gnt <= 1'b1;
            r_state   <= ST_MEM;
          end
        end
        ST_SNOOP: begin
          if (!Com_Bus_Req_snoop[r_snoop_idx]) begin
            r_gnt_snoop     <= '0;
            r_gnt_snoop_any <= 1'b0;
            r_state         <= ST_PROC;
          end
        end
        ST_MEM: begin
          if (!Mem_snoop_req) begin
            r_mem_gnt <= 1'b0;
            r_state   <= ST_PROC;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign Com_Bus_Gnt_proc      = r_gnt_proc;
  assign Com_Bus_Gnt_snoop_vec = r_gnt_snoop;
  assign Com_Bus_Gnt_snoop     = r_gnt_snoop_any;
  assign Mem_snoop_gnt         = r_mem_gnt;
  assign Bus_owner             = r_owner;

endmodule

// File: tb/tb_com_bus_arbiter.sv
// Scoreboard bench for com_bus_arbiter: per-cycle stimulus tables with expected grants.
module tb_com_bus_arbiter;

  typedef struct packed {
    logic [7:0] gp;
    logic [3:0] gs;
    logic       gsa;
    logic       mg;
    logic [2:0] own;
  } out_t;

  typedef struct packed {
    logic [7:0] p;
    logic [3:0] s;
    logic       m;
    logic [7:0] gp;
    logic [3:0] gs;
    logic       mg;
  } cyc_t;

  logic       clk;
  logic       rst;
  logic [7:0] req_p;
  logic [3:0] req_s;
  logic       mreq;
  logic [7:0] gnt_p;
  logic [3:0] gnt_s;
  logic       gnt_sa;
  logic       mgnt;
  logic [2:0] own;

  out_t sb[$];
  int   n_chk;
  int   n_pass;

  com_bus_arbiter dut (
    .clk                   (clk),
    .rst                   (rst),
    .Com_Bus_Req_proc      (req_p),
    .Com_Bus_Req_snoop     (req_s),
    .Mem_snoop_req         (mreq),
    .Com_Bus_Gnt_proc      (gnt_p),
    .Com_Bus_Gnt_snoop_vec (gnt_s),
    .Com_Bus_Gnt_snoop     (gnt_sa),
    .Mem_snoop_gnt         (mgnt),
    .Bus_owner             (own)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic cyc_t mk(logic [7:0] p, logic [3:0] s, logic m,
                              logic [7:0] gp, logic [3:0] gs, logic mg);
    cyc_t c;
    c.p = p; c.s = s; c.m = m; c.gp = gp; c.gs = gs; c.mg = mg;
    return c;
  endfunction

  function automatic out_t exp_of(cyc_t c);
    out_t e;
    e.gp  = c.gp;
    e.gs  = c.gs;
    e.gsa = |c.gs;
    e.mg  = c.mg;
    e.own = 3'd0;
    for (int i = 0; i < 8; i++) if (c.gp[i]) e.own = 3'(i);
    return e;
  endfunction

  // Bus_owner is only meaningful while a proc grant is active.
  function automatic out_t observed();
    out_t o;
    o.gp  = gnt_p;
    o.gs  = gnt_s;
    o.gsa = gnt_sa;
    o.mg  = mgnt;
    o.own = (gnt_p != 8'h00) ? own : 3'd0;
    return o;
  endfunction

  task automatic test_reset();
    cyc_t cy[$];
    out_t e, o;
    rst = 1'b1; req_p = 8'hFF; req_s = 4'hF; mreq = 1'b1;
    #2;
    sb.push_back(out_t'(0));
    e = sb.pop_front(); o = observed(); n_chk++;
    if (o !== e) $display("FAIL reset_hold: got %h want %h", o, e); else n_pass++;
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    cy.push_back(mk(8'hFF, 4'hF, 1'b1, 8'h01, 4'h0, 1'b0));
    cy.push_back(mk(8'hFF, 4'hF, 1'b1, 8'h01, 4'h1, 1'b0));
    foreach (cy[i]) begin
      req_p = cy[i].p; req_s = cy[i].s; mreq = cy[i].m;
      sb.push_back(exp_of(cy[i]));
      @(posedge clk); #1;
      e = sb.pop_front(); o = observed(); n_chk++;
      if (o !== e) $display("FAIL reset_all_req[%0d]: got %h want %h", i, o, e); else n_pass++;
    end
    rst = 1'b1;
    #1;
    sb.push_back(out_t'(0));
    e = sb.pop_front(); o = observed(); n_chk++;
    if (o !== e) $display("FAIL reset_async: got %h want %h", o, e); else n_pass++;
    @(negedge clk); rst = 1'b0; req_p = 8'h00; req_s = 4'h0; mreq = 1'b0;
    sb.push_back(out_t'(0));
    @(posedge clk); #1;
    e = sb.pop_front(); o = observed(); n_chk++;
    if (o !== e) $display("FAIL reset_idle: got %h want %h", o, e); else n_pass++;
  endtask

  task automatic test_rr_sequence();
    cyc_t cy[$];
    out_t e, o;
    logic [7:0] cur, bit_k;
    cur = 8'hFF;
    for (int k = 0; k < 8; k++) begin
      bit_k = 8'b1 << k;
      repeat (3) cy.push_back(mk(cur, 4'h0, 1'b0, bit_k, 4'h0, 1'b0));
      cur = cur & ~bit_k;
      cy.push_back(mk(cur, 4'h0, 1'b0, 8'h00, 4'h0, 1'b0));
    end
    foreach (cy[i]) begin
      req_p = cy[i].p; req_s = cy[i].s; mreq = cy[i].m;
      sb.push_back(exp_of(cy[i]));
      @(posedge clk); #1;
      e = sb.pop_front(); o = observed(); n_chk++;
      if (o !== e) $display("FAIL rr_sequence[%0d]: got %h want %h", i, o, e); else n_pass++;
    end
  endtask

  task automatic test_snoop_back_to_back();
    cyc_t cy[$];
    out_t e, o;
    cy.push_back(mk(8'h04, 4'b0000, 1'b0, 8'h04, 4'b0000, 1'b0));
    cy.push_back(mk(8'h04, 4'b1010, 1'b0, 8'h04, 4'b0010, 1'b0));
    cy.push_back(mk(8'h04, 4'b1010, 1'b0, 8'h04, 4'b0010, 1'b0));
    cy.push_back(mk(8'h04, 4'b1000, 1'b0, 8'h04, 4'b0000, 1'b0));
    cy.push_back(mk(8'h04, 4'b1000, 1'b0, 8'h04, 4'b1000, 1'b0));
    cy.push_back(mk(8'h04, 4'b1000, 1'b0, 8'h04, 4'b1000, 1'b0));
    cy.push_back(mk(8'h04, 4'b0000, 1'b0, 8'h04, 4'b0000, 1'b0));
    cy.push_back(mk(8'h00, 4'b0000, 1'b0, 8'h00, 4'b0000, 1'b0));
    cy.push_back(mk(8'h00, 4'b0000, 1'b0, 8'h00, 4'b0000, 1'b0));
    foreach (cy[i]) begin
      req_p = cy[i].p; req_s = cy[i].s; mreq = cy[i].m;
      sb.push_back(exp_of(cy[i]));
      @(posedge clk); #1;
      e = sb.pop_front(); o = observed(); n_chk++;
      if (o !== e) $display("FAIL snoop_b2b[%0d]: got %h want %h", i, o, e); else n_pass++;
    end
  endtask

  task automatic test_snoop_before_mem();
    cyc_t cy[$];
    out_t e, o;
    cy.push_back(mk(8'h20, 4'b0000, 1'b0, 8'h20, 4'b0000, 1'b0));
    cy.push_back(mk(8'h20, 4'b0001, 1'b1, 8'h20, 4'b0001, 1'b0));
    cy.push_back(mk(8'h20, 4'b0001, 1'b1, 8'h20, 4'b0001, 1'b0));
    cy.push_back(mk(8'h20, 4'b0000, 1'b1, 8'h20, 4'b0000, 1'b0));
    cy.push_back(mk(8'h20, 4'b0000, 1'b1, 8'h20, 4'b0000, 1'b1));
    cy.push_back(mk(8'h20, 4'b0000, 1'b1, 8'h20, 4'b0000, 1'b1));
    cy.push_back(mk(8'h20, 4'b0000, 1'b0, 8'h20, 4'b0000, 1'b0));
    cy.push_back(mk(8'h00, 4'b0000, 1'b0, 8'h00, 4'b0000, 1'b0));
    foreach (cy[i]) begin
      req_p = cy[i].p; req_s = cy[i].s; mreq = cy[i].m;
      sb.push_back(exp_of(cy[i]));
      @(posedge clk); #1;
      e = sb.pop_front(); o = observed(); n_chk++;
      if (o !== e) $display("FAIL snoop_before_mem[%0d]: got %h want %h", i, o, e); else n_pass++;
    end
  endtask

  task automatic test_owner_drop_in_mem();
    cyc_t cy[$];
    out_t e, o;
    cy.push_back(mk(8'h01, 4'h0, 1'b0, 8'h01, 4'h0, 1'b0));
    cy.push_back(mk(8'h01, 4'h0, 1'b1, 8'h01, 4'h0, 1'b1));
    cy.push_back(mk(8'h00, 4'h0, 1'b1, 8'h01, 4'h0, 1'b1));
    cy.push_back(mk(8'h00, 4'h0, 1'b1, 8'h01, 4'h0, 1'b1));
    cy.push_back(mk(8'h00, 4'h0, 1'b0, 8'h01, 4'h0, 1'b0));
    cy.push_back(mk(8'h00, 4'h0, 1'b0, 8'h00, 4'h0, 1'b0));
    foreach (cy[i]) begin
      req_p = cy[i].p; req_s = cy[i].s; mreq = cy[i].m;
      sb.push_back(exp_of(cy[i]));
      @(posedge clk); #1;
      e = sb.pop_front(); o = observed(); n_chk++;
      if (o !== e) $display("FAIL owner_drop_mem[%0d]: got %h want %h", i, o, e); else n_pass++;
    end
  endtask

  task automatic test_wraparound();
    cyc_t cy[$];
    out_t e, o;
    cy.push_back(mk(8'h80, 4'h0, 1'b0, 8'h80, 4'h0, 1'b0));
    cy.push_back(mk(8'h00, 4'h0, 1'b0, 8'h00, 4'h0, 1'b0));
    cy.push_back(mk(8'h81, 4'h0, 1'b0, 8'h01, 4'h0, 1'b0));
    cy.push_back(mk(8'h80, 4'h0, 1'b0, 8'h00, 4'h0, 1'b0));
    cy.push_back(mk(8'h81, 4'h0, 1'b0, 8'h80, 4'h0, 1'b0));
    cy.push_back(mk(8'h01, 4'h0, 1'b0, 8'h00, 4'h0, 1'b0));
    cy.push_back(mk(8'h08, 4'h0, 1'b0, 8'h08, 4'h0, 1'b0));
    cy.push_back(mk(8'h00, 4'h0, 1'b0, 8'h00, 4'h0, 1'b0));
    cy.push_back(mk(8'h81, 4'h0, 1'b0, 8'h80, 4'h0, 1'b0));
    cy.push_back(mk(8'h00, 4'h0, 1'b0, 8'h00, 4'h0, 1'b0));
    foreach (cy[i]) begin
      req_p = cy[i].p; req_s = cy[i].s; mreq = cy[i].m;
      sb.push_back(exp_of(cy[i]));
      @(posedge clk); #1;
      e = sb.pop_front(); o = observed(); n_chk++;
      if (o !== e) $display("FAIL wraparound[%0d]: got %h want %h", i, o, e); else n_pass++;
    end
  endtask

  task automatic test_reset_mid_snoop();
    cyc_t cy[$];
    cyc_t post[$];
    out_t e, o;
    cy.push_back(mk(8'h08, 4'b0000, 1'b0, 8'h08, 4'b0000, 1'b0));
    cy.push_back(mk(8'h08, 4'b0100, 1'b0, 8'h08, 4'b0100, 1'b0));
    cy.push_back(mk(8'h08, 4'b0100, 1'b0, 8'h08, 4'b0100, 1'b0));
    foreach (cy[i]) begin
      req_p = cy[i].p; req_s = cy[i].s; mreq = cy[i].m;
      sb.push_back(exp_of(cy[i]));
      @(posedge clk); #1;
      e = sb.pop_front(); o = observed(); n_chk++;
      if (o !== e) $display("FAIL mid_snoop[%0d]: got %h want %h", i, o, e); else n_pass++;
    end
    rst = 1'b1;
    #1;
    sb.push_back(out_t'(0));
    e = sb.pop_front(); o = observed(); n_chk++;
    if (o !== e) $display("FAIL mid_snoop_async_rst: got %h want %h", o, e); else n_pass++;
    @(posedge clk);
    @(negedge clk); rst = 1'b0;
    post.push_back(mk(8'h09, 4'h0, 1'b0, 8'h01, 4'h0, 1'b0));
    post.push_back(mk(8'h08, 4'h0, 1'b0, 8'h00, 4'h0, 1'b0));
    post.push_back(mk(8'h08, 4'h0, 1'b0, 8'h08, 4'h0, 1'b0));
    post.push_back(mk(8'h00, 4'h0, 1'b0, 8'h00, 4'h0, 1'b0));
    foreach (post[i]) begin
      req_p = post[i].p; req_s = post[i].s; mreq = post[i].m;
      sb.push_back(exp_of(post[i]));
      @(posedge clk); #1;
      e = sb.pop_front(); o = observed(); n_chk++;
      if (o !== e) $display("FAIL post_reset[%0d]: got %h want %h", i, o, e); else n_pass++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d passed=%0d", n_chk, n_pass);
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_chk = 0; n_pass = 0;
    rst = 1'b1; req_p = 8'h00; req_s = 4'h0; mreq = 1'b0;
    test_reset();
    test_rr_sequence();
    test_snoop_back_to_back();
    test_snoop_before_mem();
    test_owner_drop_in_mem();
    test_wraparound();
    test_reset_mid_snoop();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
